// File: rtl/sound_arbiter_if.sv
// rtl/sound_arbiter_if.sv - event/level inputs and speaker outputs of the sound arbiter
interface sound_arbiter_if;
    logic       wall;
    logic       hit;
    logic       goal;
    logic       p1_win;
    logic       p2_win;
    logic       mute;
    logic       tone;
    logic       busy;
    logic [2:0] cur_evt;

    modport master (
        output wall, hit, goal, p1_win, p2_win, mute,
        input  tone, busy, cur_evt
    );

    modport slave (
        input  wall, hit, goal, p1_win, p2_win, mute,
        output tone, busy, cur_evt
    );
endinterface

// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - prioritised game sound arbiter; SOUND_WIN_MELODY_EN selects the 3-note win melody
module sound_arbiter #(
    parameter int TICK_DIV  = 25000,
    parameter int WALL_HALF = 50000,
    parameter int HIT_HALF  = 25000,
    parameter int GOAL_HALF = 12500,
    parameter int MID_HALF  = 18750,
    parameter int WALL_MS   = 30,
    parameter int HIT_MS    = 50,
    parameter int GOAL_MS   = 200,
    parameter int NOTE_MS   = 150,
    parameter int GAP_MS    = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    sound_arbiter_if.slave    snd
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int HALF_MAX = max2(max2(WALL_HALF, HIT_HALF), max2(GOAL_HALF, MID_HALF));
    localparam int DUR_MAX  = max2(max2(max2(WALL_MS, HIT_MS), max2(GOAL_MS, 3 * NOTE_MS)), GAP_MS);
    localparam int HW = $clog2(HALF_MAX + 1);
    localparam int DW = $clog2(DUR_MAX + 1);
    localparam int TW = $clog2(TICK_DIV + 1);

    localparam logic [2:0] EV_NONE = 3'd0;
    localparam logic [2:0] EV_WALL = 3'd1;
    localparam logic [2:0] EV_HIT  = 3'd2;
    localparam logic [2:0] EV_GOAL = 3'd3;
    localparam logic [2:0] EV_WIN  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;

    state_t          r_state, w_state_n;
    logic [2:0]      r_evt, w_evt_n;
    logic [3:0]      r_pend, w_pend_n;
    logic            r_win_d;
    logic            r_armed;
    logic            r_tone;
    logic [HW-1:0]   r_hcnt;
    logic [TW-1:0]   r_div;
    logic [DW-1:0]   r_tcnt;
`ifdef SOUND_WIN_MELODY_EN
    logic [1:0]      r_note, w_note_n;
`endif

    logic            w_win_lvl, w_win_edge;
    logic [3:0]      w_set, w_req, w_grant;
    logic [2:0]      w_top;
    logic [HW-1:0]   w_half_m1;
    logic [DW-1:0]   w_tlast;
    logic            w_tick_end, w_note_end, w_preempt, w_restart;

    // r_armed blocks a false win edge when a win level is already high at reset release
    always_comb begin
        w_win_lvl  = snd.p1_win | snd.p2_win;
        w_win_edge = w_win_lvl & ~r_win_d & r_armed;
        w_set      = snd.mute ? 4'b0000 : {w_win_edge, snd.goal, snd.hit, snd.wall};
        w_req      = r_pend | w_set;
        w_top      = w_req[3] ? EV_WIN  :
                     w_req[2] ? EV_GOAL :
                     w_req[1] ? EV_HIT  :
                     w_req[0] ? EV_WALL : EV_NONE;
        w_preempt  = (((r_evt == EV_WALL) || (r_evt == EV_HIT)) && (w_req[2] || w_req[3])) ||
                     ((r_evt == EV_GOAL) && w_req[3]);
    end

    always_comb begin
        w_half_m1 = HW'(GOAL_HALF - 1);
        w_tlast   = DW'(GOAL_MS - 1);
        case (r_evt)
            EV_WALL: begin w_half_m1 = HW'(WALL_HALF - 1); w_tlast = DW'(WALL_MS - 1); end
            EV_HIT:  begin w_half_m1 = HW'(HIT_HALF - 1);  w_tlast = DW'(HIT_MS - 1);  end
            EV_WIN: begin
`ifdef SOUND_WIN_MELODY_EN
                w_tlast = DW'(NOTE_MS - 1);
                case (r_note)
                    2'd0:    w_half_m1 = HW'(HIT_HALF - 1);
                    2'd1:    w_half_m1 = HW'(MID_HALF - 1);
                    default: w_half_m1 = HW'(GOAL_HALF - 1);
                endcase
`else
                w_half_m1 = HW'(GOAL_HALF - 1);
                w_tlast   = DW'(3 * NOTE_MS - 1);
`endif
            end
            default: ;
        endcase
        if (r_state == ST_GAP) begin
            w_tlast = DW'(GAP_MS - 1);
        end
        w_tick_end = (r_div == TW'(TICK_DIV - 1));
        w_note_end = w_tick_end && (r_tcnt == w_tlast);
    end

    always_comb begin
        w_state_n = r_state;
        w_evt_n   = r_evt;
        w_grant   = 4'b0000;
        w_restart = 1'b0;
`ifdef SOUND_WIN_MELODY_EN
        w_note_n  = r_note;
`endif
        if (snd.mute) begin
            w_state_n = ST_IDLE;
            w_evt_n   = EV_NONE;
            w_restart = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_evt_n = EV_NONE;
                    if (|w_req) begin
                        w_grant   = 4'b0001 << (w_top - 3'd1);
                        w_evt_n   = w_top;
                        w_state_n = ST_PLAY;
                        w_restart = 1'b1;
`ifdef SOUND_WIN_MELODY_EN
                        w_note_n  = 2'd0;
`endif
                    end
                end
                ST_PLAY: begin
                    if (w_preempt) begin
                        w_state_n = ST_IDLE;
                        w_evt_n   = EV_NONE;
                        w_restart = 1'b1;
                    end else if (w_note_end) begin
                        w_state_n = ST_GAP;
                        w_restart = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_preempt) begin
                        w_state_n = ST_IDLE;
                        w_evt_n   = EV_NONE;
                        w_restart = 1'b1;
                    end else if (w_note_end) begin
                        w_state_n = ST_IDLE;
                        w_evt_n   = EV_NONE;
                        w_restart = 1'b1;
`ifdef SOUND_WIN_MELODY_EN
                        if ((r_evt == EV_WIN) && (r_note != 2'd2)) begin
                            w_state_n = ST_PLAY;
                            w_evt_n   = EV_WIN;
                            w_note_n  = r_note + 2'd1;
                        end
`endif
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_evt_n   = EV_NONE;
                    w_restart = 1'b1;
                end
            endcase
        end
        // a pulse consumed by its own grant must not re-arm; one arriving on top of an older pending bit does
        w_pend_n = snd.mute ? 4'b0000 : ((r_pend & ~w_grant) | (w_set & ~(w_grant & ~r_pend)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt   <= EV_NONE;
            r_pend  <= 4'b0000;
            r_win_d <= 1'b0;
            r_armed <= 1'b0;
            r_tone  <= 1'b0;
            r_hcnt  <= '0;
            r_div   <= '0;
            r_tcnt  <= '0;
`ifdef SOUND_WIN_MELODY_EN
            r_note  <= 2'd0;
`endif
        end else begin
            r_evt   <= w_evt_n;
            r_pend  <= w_pend_n;
            r_win_d <= w_win_lvl;
            r_armed <= 1'b1;
`ifdef SOUND_WIN_MELODY_EN
            r_note  <= w_note_n;
`endif
            if (w_restart) begin
                r_tone <= 1'b0;
                r_hcnt <= '0;
                r_div  <= '0;
                r_tcnt <= '0;
            end else if (r_state != ST_IDLE) begin
                if (w_tick_end) begin
                    r_div  <= '0;
                    r_tcnt <= r_tcnt + DW'(1);
                end else begin
                    r_div  <= r_div + TW'(1);
                end
                if (r_state == ST_PLAY) begin
                    if (r_hcnt == w_half_m1) begin
                        r_hcnt <= '0;
                        r_tone <= ~r_tone;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end else begin
                    r_tone <= 1'b0;
                end
            end
        end
    end

    assign snd.tone    = r_tone;
    assign snd.busy    = (r_state != ST_IDLE);
    assign snd.cur_evt = r_evt;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb/tb_sound_arbiter.sv - directed self-checking bench for sound_arbiter
module tb_sound_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef SOUND_WIN_MELODY_EN
    localparam int WIN_END = 101;
    localparam int WIN_T6  = 0;
`else
    localparam int WIN_END = 85;
    localparam int WIN_T6  = 1;
`endif

    sound_arbiter_if snd();

    sound_arbiter #(
        .TICK_DIV (4),
        .WALL_HALF(4),
        .HIT_HALF (2),
        .GOAL_HALF(1),
        .WALL_MS  (3),
        .HIT_MS   (5),
        .GOAL_MS  (8),
        .NOTE_MS  (6),
        .GAP_MS   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .snd  (snd)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic upto(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        snd.wall = 0; snd.hit = 0; snd.goal = 0;
        snd.p1_win = 0; snd.p2_win = 0; snd.mute = 0;
        repeat (2) @(negedge clk);
        check("rst_tone", snd.tone, 0);
        check("rst_busy", snd.busy, 0);
        check("rst_evt", snd.cur_evt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single hit: 20 clocks of tone toggling every 2, then 8-clock gap
        snd.hit = 1; cyc = 0; tick(); snd.hit = 0;
        check("t1_evt", snd.cur_evt, 2);
        for (int k = 1; k <= 28; k++) begin
            upto(k);
            check("t1_tone", snd.tone, (k <= 20) ? ((k - 1) / 2) % 2 : 0);
        end
        check("t1_busy_gap", snd.busy, 1);
        upto(29);
        check("t1_busy_end", snd.busy, 0);
        check("t1_evt_end", snd.cur_evt, 0);
        repeat (3) tick();

        // simultaneous wall/hit/goal served goal, hit, wall
        snd.wall = 1; snd.hit = 1; snd.goal = 1; cyc = 0; tick();
        snd.wall = 0; snd.hit = 0; snd.goal = 0;
        check("t2_goal", snd.cur_evt, 3);
        upto(2);  check("t2_tone2", snd.tone, 1);
        upto(40); check("t2_goal_last", snd.cur_evt, 3);
        upto(41); check("t2_idle1", snd.cur_evt, 0); check("t2_idle1_busy", snd.busy, 0);
        upto(42); check("t2_hit", snd.cur_evt, 2);
        upto(70); check("t2_idle2", snd.cur_evt, 0);
        upto(71); check("t2_wall", snd.cur_evt, 1);
        upto(90); check("t2_wall_gap", snd.busy, 1);
        upto(91); check("t2_done_busy", snd.busy, 0); check("t2_done_evt", snd.cur_evt, 0);
        upto(95); check("t2_quiet", snd.cur_evt, 0);

        // goal aborts hit; hit is not replayed
        snd.hit = 1; cyc = 0; tick(); snd.hit = 0;
        upto(5); check("t3_hit", snd.cur_evt, 2);
        snd.goal = 1; tick(); snd.goal = 0;
        check("t3_abort_tone", snd.tone, 0);
        upto(7);  check("t3_goal", snd.cur_evt, 3);
        upto(46); check("t3_goal_gap", snd.cur_evt, 3);
        upto(47); check("t3_idle", snd.busy, 0);
        upto(52); check("t3_no_replay_busy", snd.busy, 0); check("t3_no_replay_evt", snd.cur_evt, 0);

        // win preempts goal; goal pulsed during win only latches
        snd.goal = 1; cyc = 0; tick(); snd.goal = 0;
        upto(3); check("t4_goal", snd.cur_evt, 3);
        snd.p1_win = 1; tick();
        check("t4_abort", snd.cur_evt, 0);
        upto(5); check("t4_win", snd.cur_evt, 4);
        upto(6); check("t4_win_tone", snd.tone, WIN_T6);
        upto(10); snd.goal = 1; tick(); snd.goal = 0;
        check("t4_win_kept", snd.cur_evt, 4);
        upto(20); snd.p1_win = 0;
        upto(WIN_END - 1); check("t4_win_last", snd.cur_evt, 4); check("t4_win_busy", snd.busy, 1);
        upto(WIN_END);     check("t4_win_idle", snd.cur_evt, 0);
        upto(WIN_END + 1); check("t4_goal_after", snd.cur_evt, 3);
        upto(WIN_END + 41); check("t4_end_busy", snd.busy, 0); check("t4_end_evt", snd.cur_evt, 0);

        // mute mid-note flushes pending wall and ignores new events
        snd.hit = 1; cyc = 0; tick(); snd.hit = 0;
        upto(2); snd.wall = 1; tick(); snd.wall = 0;
        check("t5_tone_on", snd.tone, 1);
        snd.mute = 1; tick();
        check("t5_mute_tone", snd.tone, 0);
        check("t5_mute_busy", snd.busy, 0);
        check("t5_mute_evt", snd.cur_evt, 0);
        tick(); snd.goal = 1; tick(); snd.goal = 0;
        snd.mute = 0;
        upto(10); check("t5_flushed_busy", snd.busy, 0); check("t5_flushed_evt", snd.cur_evt, 0);

        // asynchronous reset mid-win, no replay with win level still high
        snd.p1_win = 1; cyc = 0; tick();
        check("t6_win", snd.cur_evt, 4);
        upto(4); check("t6_tone", snd.tone, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tone", snd.tone, 0);
        check("t6_rst_busy", snd.busy, 0);
        check("t6_rst_evt", snd.cur_evt, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) tick();
        check("t6_norep_busy", snd.busy, 0);
        check("t6_norep_evt", snd.cur_evt, 0);
        snd.p1_win = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter TICK_DIV, 25000, clocks per 1 ms tick (25 MHz pixel clock).
REQ-002 Parameter WALL_HALF, 50000, wall tone half-period in clocks (250 Hz).
REQ-003 Parameter HIT_HALF, 25000, hit tone half-period in clocks (500 Hz).
REQ-004 Parameter GOAL_HALF, 12500, goal tone half-period in clocks (1 kHz).
REQ-005 Parameters WALL_MS/HIT_MS/GOAL_MS/NOTE_MS/GAP_MS, 30/50/200/150/20, note and gap durations in ticks.
REQ-006 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wall, hit, goal  in  1 each  single-cycle event pulses from the game controller.
REQ-009 p1_win, p2_win  in  1 each  win levels.
REQ-010 mute  in  1  level; silences and flushes the block.
REQ-011 tone  out  1  square wave to the speaker.
REQ-012 busy  out  1  high in PLAY or GAP.
REQ-013 cur_evt  out  3  event being served: 0 none, 1 wall, 2 hit, 3 goal, 4 win.

Function
REQ-014 SHALL hold one pending bit per event; pulse sets it; win pending set on rising edge of (p1_win|p2_win).
REQ-015 Set SHALL win over clear when an event arrives on the cycle its pending bit is granted.
REQ-016 FSM states SHALL be IDLE, PLAY, GAP.
REQ-017 Priority SHALL be win > goal > hit > wall; simultaneous pulses all latch and are served in that order.
REQ-018 IDLE with any pending and mute low SHALL grant highest priority on that edge, clear its bit, enter PLAY next cycle.
REQ-019 On PLAY entry tone SHALL be 0, half-period and tick counters cleared; tone toggles every HALF clocks.
REQ-020 PLAY SHALL last exactly DUR ticks (DUR*TICK_DIV clocks), then GAP for GAP_MS ticks with tone 0.
REQ-021 GAP end SHALL go to next melody note (win) or IDLE; cur_evt returns to 0 in IDLE.
REQ-022 Pending goal or win during wall/hit PLAY or GAP SHALL abort it; new grant on next edge, tone 0 for that one cycle.
REQ-023 Pending win SHALL preempt goal; nothing preempts win.
REQ-024 Equal or lower priority events during playback SHALL only latch.
REQ-025 mute high SHALL force IDLE, tone 0, clear all pending, and ignore events while high.
REQ-026 Counters SHALL be sized for parameter maxima; no wrap occurs within a note.

Reset
REQ-027 rst_n low SHALL immediately clear tone, busy, cur_evt, pending bits, counters, win-edge register; state IDLE.
REQ-028 Reset mid-note SHALL silence tone asynchronously; no event resumes after release.

Configuration
REQ-029 SOUND_WIN_MELODY_EN defined: win plays three NOTE_MS notes at half-periods HIT_HALF, 18750, GOAL_HALF with GAP_MS gaps.
REQ-030 SOUND_WIN_MELODY_EN undefined: win plays one GOAL_HALF note of 3*NOTE_MS ticks, then GAP, then IDLE.

Verification (bench: TICK_DIV=4, WALL_HALF=4, HIT_HALF=2, GOAL_HALF=1, WALL_MS=3, HIT_MS=5, GOAL_MS=8, NOTE_MS=6, GAP_MS=2)
REQ-031 hit pulse at cycle 0 -> cur_evt=2 cycle 1, tone toggles every 2 clocks for 20 clocks, 8-clock gap, IDLE.
REQ-032 wall, hit, goal pulsed same cycle -> order goal, hit, wall; each separated by 8-clock gap.
REQ-033 goal pulse mid hit tone -> hit aborted, cur_evt=3 within 2 cycles, hit not replayed.
REQ-034 p1_win rises during goal -> win preempts; goal pulse during win only latches, plays after win.
REQ-035 mute high mid-note with wall pending -> tone 0 next cycle, pending cleared, IDLE after mute falls.
REQ-036 rst_n low mid-win -> tone/busy 0 asynchronously; release with p1_win still high -> no replay.
